// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder: decode-mode encodings,
// transition-classification constants and the position-width helper.
package quad_pkg;

    // Decode mode as presented on the mode input.
    typedef enum logic [1:0] {
        MODE_X1  = 2'b00,
        MODE_X2  = 2'b01,
        MODE_X4  = 2'b10,
        MODE_RSV = 2'b11
    } mode_e;

    // Classification of one {A,B} -> {A,B} transition.
    typedef enum logic [1:0] {
        TR_NONE    = 2'b00,
        TR_CW      = 2'b01,
        TR_ACW     = 2'b10,
        TR_ILLEGAL = 2'b11
    } trans_e;

    // Transition codes are {prev_a, prev_b, cur_a, cur_b}.
    // Clockwise sequence 00 -> 01 -> 11 -> 10 -> 00.
    localparam logic [3:0] T_CW_00_01  = 4'b0001;
    localparam logic [3:0] T_CW_01_11  = 4'b0111;
    localparam logic [3:0] T_CW_11_10  = 4'b1110;
    localparam logic [3:0] T_CW_10_00  = 4'b1000;
    // Anticlockwise is the reverse walk.
    localparam logic [3:0] T_ACW_00_10 = 4'b0010;
    localparam logic [3:0] T_ACW_10_11 = 4'b1011;
    localparam logic [3:0] T_ACW_11_01 = 4'b1101;
    localparam logic [3:0] T_ACW_01_00 = 4'b0100;
    // Both channels moving in one sample: direction is unknowable.
    localparam logic [3:0] T_ILL_00_11 = 4'b0011;
    localparam logic [3:0] T_ILL_01_10 = 4'b0110;
    localparam logic [3:0] T_ILL_10_01 = 4'b1001;
    localparam logic [3:0] T_ILL_11_00 = 4'b1100;

    // Smallest width able to hold 0 .. 4*cpr-1.
    function automatic int quad_pos_width(input int cpr);
        longint span;
        int     w;
        span = 64'(4) * longint'(cpr);
        w    = 1;
        while ((64'(1) << w) < span) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Classify a transition between two filtered {A,B} samples.
    function automatic trans_e quad_classify(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
        trans_e t;
        case ({prev_ab, cur_ab})
            T_CW_00_01, T_CW_01_11, T_CW_11_10, T_CW_10_00:     t = TR_CW;
            T_ACW_00_10, T_ACW_10_11, T_ACW_11_01, T_ACW_01_00: t = TR_ACW;
            T_ILL_00_11, T_ILL_01_10, T_ILL_10_01, T_ILL_11_00: t = TR_ILLEGAL;
            default:                                            t = TR_NONE;
        endcase
        return t;
    endfunction

    // Decide whether a legal transition advances the count in this mode.
    // x2 counts only edges of A; x1 counts only the 10<->00 edge of A.
    function automatic logic quad_counted(input trans_e     t,
                                          input logic [3:0] code,
                                          input logic [1:0] mode);
        logic c;
        c = 1'b0;
        if ((t == TR_CW) || (t == TR_ACW)) begin
            case (mode)
                MODE_X1: c = (code == T_CW_10_00) || (code == T_ACW_00_10);
                MODE_X2: c = (code[3] != code[1]);
                default: c = 1'b1;
            endcase
        end else begin
            c = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/quad_glitch_filter.sv
// Three-flop synchroniser followed by a run-length glitch filter: the output
// only follows the input after FILT_LEN consecutive samples that differ from it.
module quad_glitch_filter
    import quad_pkg::*;
#(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic [2:0] sync_r;
    logic [3:0] cnt_r;
    logic       filt_r;
    logic [3:0] cnt_next_s;
    logic       filt_next_s;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 3'b000;
        end else begin
            sync_r <= {sync_r[1:0], din};
        end
    end

    // Count differing samples; any agreeing sample restarts the run.
    always_comb begin
        cnt_next_s  = 4'd0;
        filt_next_s = filt_r;
        if (sync_r[2] == filt_r) begin
            cnt_next_s = 4'd0;
        end else if (cnt_r == CNT_LAST) begin
            filt_next_s = sync_r[2];
            cnt_next_s  = 4'd0;
        end else begin
            cnt_next_s = cnt_r + 4'd1;
        end
    end

    // Filter state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= 4'd0;
            filt_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_next_s;
            filt_r <= filt_next_s;
        end
    end

    assign dout = filt_r;

endmodule

// File: rtl/quad_decoder_idx.sv
// Quadrature decoder with selectable x1/x2/x4 resolution, illegal-transition
// counting, armed index capture and step-period measurement.
module quad_decoder_idx
    import quad_pkg::*;
#(
    parameter int   CPR        = 4096,
    parameter int   FILT_LEN   = 4,
    parameter int   PER_W      = 20,
    parameter logic INDEX_ZERO = 1'b1,
    parameter logic INVERT_A   = 1'b0,
    parameter logic INVERT_B   = 1'b0,
    parameter logic INVERT_Z   = 1'b0,
    localparam int  POS_W      = quad_pos_width(CPR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             z_in,
    input  logic [1:0]       mode,
    input  logic             zero_req,
    input  logic             index_arm,
    output logic [POS_W-1:0] pos,
    output logic             step_pulse,
    output logic             dir,
    output logic             illegal,
    output logic [7:0]       err_cnt,
    output logic [POS_W-1:0] index_pos,
    output logic             index_valid,
    output logic             index_armed,
    output logic [PER_W-1:0] period,
    output logic             period_valid
);

    localparam logic [POS_W-1:0] MAX_X1  = POS_W'(CPR - 1);
    localparam logic [POS_W-1:0] MAX_X2  = POS_W'(2 * CPR - 1);
    localparam logic [POS_W-1:0] MAX_X4  = POS_W'(4 * CPR - 1);
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    logic             a_filt_s;
    logic             b_filt_s;
    logic             z_filt_s;

    logic [1:0]       prev_ab_r;
    logic             z_prev_r;
    logic             seeded_r;
    logic [1:0]       mode_prev_r;

    logic [POS_W-1:0] pos_r;
    logic             step_r;
    logic             dir_r;
    logic             illegal_r;
    logic [7:0]       err_cnt_r;
    logic [POS_W-1:0] index_pos_r;
    logic             index_valid_r;
    logic             index_armed_r;
    logic [PER_W-1:0] period_r;
    logic             period_valid_r;
    logic [PER_W-1:0] per_cnt_r;

    logic [1:0]       cur_ab_s;
    trans_e           trans_s;
    logic             mode_chg_s;
    logic             count_s;
    logic             illegal_s;
    logic             capture_s;
    logic [POS_W-1:0] pos_max_s;
    logic [POS_W-1:0] pos_step_s;
    logic [POS_W-1:0] pos_next_s;
    logic [7:0]       err_next_s;
    logic             armed_next_s;
    logic [PER_W-1:0] per_inc_s;

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
        .clk  (clk),
        .rst  (rst),
        .din  (a_in ^ INVERT_A),
        .dout (a_filt_s)
    );

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
        .clk  (clk),
        .rst  (rst),
        .din  (b_in ^ INVERT_B),
        .dout (b_filt_s)
    );

    quad_glitch_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
        .clk  (clk),
        .rst  (rst),
        .din  (z_in ^ INVERT_Z),
        .dout (z_filt_s)
    );

    // Classify the current transition and qualify steps, errors and capture.
    // Nothing is acted on until the previous-state registers hold real data.
    always_comb begin
        cur_ab_s   = {a_filt_s, b_filt_s};
        trans_s    = quad_classify(prev_ab_r, cur_ab_s);
        mode_chg_s = seeded_r && (mode != mode_prev_r);
        count_s    = seeded_r && !mode_chg_s
                     && quad_counted(trans_s, {prev_ab_r, cur_ab_s}, mode);
        illegal_s  = seeded_r && (trans_s == TR_ILLEGAL);
        capture_s  = seeded_r && index_armed_r && z_filt_s && !z_prev_r;
    end

    // Position arithmetic: modulus wrap, then clear sources by priority.
    always_comb begin
        case (mode)
            MODE_X1: pos_max_s = MAX_X1;
            MODE_X2: pos_max_s = MAX_X2;
            default: pos_max_s = MAX_X4;
        endcase

        if (trans_s == TR_CW) begin
            if (pos_r >= pos_max_s) begin
                pos_step_s = '0;
            end else begin
                pos_step_s = pos_r + POS_W'(1'b1);
            end
        end else begin
            if (pos_r == '0) begin
                pos_step_s = pos_max_s;
            end else begin
                pos_step_s = pos_r - POS_W'(1'b1);
            end
        end

        if (zero_req) begin
            pos_next_s = '0;
        end else if (capture_s && INDEX_ZERO) begin
            pos_next_s = '0;
        end else if (mode_chg_s) begin
            pos_next_s = '0;
        end else if (count_s) begin
            pos_next_s = pos_step_s;
        end else begin
            pos_next_s = pos_r;
        end
    end

    // Error count saturation, arm handling and period-counter saturation.
    always_comb begin
        if (illegal_s && (err_cnt_r != 8'hFF)) begin
            err_next_s = err_cnt_r + 8'd1;
        end else begin
            err_next_s = err_cnt_r;
        end

        if (capture_s) begin
            armed_next_s = 1'b0;
        end else if (index_arm) begin
            armed_next_s = 1'b1;
        end else begin
            armed_next_s = index_armed_r;
        end

        if (per_cnt_r == PER_MAX) begin
            per_inc_s = PER_MAX;
        end else begin
            per_inc_s = per_cnt_r + PER_W'(1'b1);
        end
    end

    // Remember the previous filtered inputs and mode; the first cycle out
    // of reset only seeds these.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab_r   <= 2'b00;
            z_prev_r    <= 1'b0;
            seeded_r    <= 1'b0;
            mode_prev_r <= 2'b00;
        end else begin
            prev_ab_r   <= cur_ab_s;
            z_prev_r    <= z_filt_s;
            seeded_r    <= 1'b1;
            mode_prev_r <= mode;
        end
    end

    // Position, step/direction reporting and illegal-transition tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_r     <= '0;
            step_r    <= 1'b0;
            dir_r     <= 1'b0;
            illegal_r <= 1'b0;
            err_cnt_r <= 8'd0;
        end else begin
            pos_r     <= pos_next_s;
            step_r    <= count_s;
            illegal_r <= illegal_s;
            err_cnt_r <= err_next_s;
            if (count_s) begin
                dir_r <= (trans_s == TR_CW);
            end else begin
                dir_r <= dir_r;
            end
        end
    end

    // Index capture latches the position as it stood before this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index_pos_r   <= '0;
            index_valid_r <= 1'b0;
            index_armed_r <= 1'b0;
        end else begin
            index_valid_r <= capture_s;
            index_armed_r <= armed_next_s;
            if (capture_s) begin
                index_pos_r <= pos_r;
            end else begin
                index_pos_r <= index_pos_r;
            end
        end
    end

    // Clocks-between-steps measurement; starts saturated so the first step
    // after reset reports the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt_r      <= PER_MAX;
            period_r       <= '0;
            period_valid_r <= 1'b0;
        end else begin
            period_valid_r <= count_s;
            if (count_s) begin
                period_r  <= per_inc_s;
                per_cnt_r <= '0;
            end else begin
                period_r  <= period_r;
                per_cnt_r <= per_inc_s;
            end
        end
    end

    assign pos          = pos_r;
    assign step_pulse   = step_r;
    assign dir          = dir_r;
    assign illegal      = illegal_r;
    assign err_cnt      = err_cnt_r;
    assign index_pos    = index_pos_r;
    assign index_valid  = index_valid_r;
    assign index_armed  = index_armed_r;
    assign period       = period_r;
    assign period_valid = period_valid_r;

endmodule

// File: tb/tb_quad_decoder_idx.sv
// Self-checking bench for quad_decoder_idx with CPR=4, FILT_LEN=4.
// Expected steps go into a scoreboard queue when stimulus is driven and are
// popped by a monitor whenever step_pulse fires.
module tb_quad_decoder_idx;

    localparam int          PER_W   = 20;
    localparam logic [31:0] PER_MAX = 32'h000F_FFFF;
    localparam logic [1:0]  M_X1    = 2'b00;
    localparam logic [1:0]  M_X2    = 2'b01;
    localparam logic [1:0]  M_X4    = 2'b10;
    localparam logic [1:0]  M_RSV   = 2'b11;
    localparam int          NVEC    = 28;

    logic             clk = 1'b0;
    logic             rst;
    logic             a_in;
    logic             b_in;
    logic             z_in;
    logic [1:0]       mode;
    logic             zero_req;
    logic             index_arm;
    logic [3:0]       pos;
    logic             step_pulse;
    logic             dir;
    logic             illegal;
    logic [7:0]       err_cnt;
    logic [3:0]       index_pos;
    logic             index_valid;
    logic             index_armed;
    logic [PER_W-1:0] period;
    logic             period_valid;

    int n_cmp        = 0;
    int n_fail       = 0;
    int steps_seen   = 0;
    int illegal_seen = 0;
    int ivalid_seen  = 0;

    typedef struct {
        logic [3:0]  pos;
        logic        dir;
        logic        chk_per;
        logic [31:0] per;
    } sb_t;

    typedef struct {
        logic       a;
        logic       b;
        logic [1:0] mode;
        logic       step;
        logic       dir;
        logic [3:0] pos;
        logic [7:0] err;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[NVEC];

    quad_decoder_idx #(
        .CPR        (4),
        .FILT_LEN   (4),
        .PER_W      (PER_W),
        .INDEX_ZERO (1'b1),
        .INVERT_A   (1'b0),
        .INVERT_B   (1'b0),
        .INVERT_Z   (1'b0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a_in         (a_in),
        .b_in         (b_in),
        .z_in         (z_in),
        .mode         (mode),
        .zero_req     (zero_req),
        .index_arm    (index_arm),
        .pos          (pos),
        .step_pulse   (step_pulse),
        .dir          (dir),
        .illegal      (illegal),
        .err_cnt      (err_cnt),
        .index_pos    (index_pos),
        .index_valid  (index_valid),
        .index_armed  (index_armed),
        .period       (period),
        .period_valid (period_valid)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_step(input logic [3:0] p, input logic d,
                               input logic cp, input logic [31:0] per);
        sb_t e;
        e.pos     = p;
        e.dir     = d;
        e.chk_per = cp;
        e.per     = per;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_pos"},          32'(pos),          32'd0);
        chk({tag, "_step"},         32'(step_pulse),   32'd0);
        chk({tag, "_dir"},          32'(dir),          32'd0);
        chk({tag, "_illegal"},      32'(illegal),      32'd0);
        chk({tag, "_err_cnt"},      32'(err_cnt),      32'd0);
        chk({tag, "_index_pos"},    32'(index_pos),    32'd0);
        chk({tag, "_index_valid"},  32'(index_valid),  32'd0);
        chk({tag, "_index_armed"},  32'(index_armed),  32'd0);
        chk({tag, "_period"},       32'(period),       32'd0);
        chk({tag, "_period_valid"}, 32'(period_valid), 32'd0);
    endtask

    function automatic logic [1:0] cw_next(input logic [1:0] ab);
        logic [1:0] n;
        case (ab)
            2'b00:   n = 2'b01;
            2'b01:   n = 2'b11;
            2'b11:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    // Scoreboard monitor: sample well after the edge, pop one expectation per step.
    always @(posedge clk) begin : mon
        sb_t e;
        #2;
        if (illegal === 1'b1) illegal_seen++;
        if (index_valid === 1'b1) ivalid_seen++;
        if (step_pulse === 1'b1) begin
            steps_seen++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_step: got pos %0d dir %0d, required no step", pos, dir);
            end else begin
                e = sb_q.pop_front();
                chk("step_pos", 32'(pos), 32'(e.pos));
                chk("step_dir", 32'(dir), 32'(e.dir));
                if (e.chk_per) begin
                    chk("step_period", 32'(period), e.per);
                    chk("step_period_valid", 32'(period_valid), 32'd1);
                end
            end
        end
    end

    initial begin
        logic [1:0] ab;
        int         s;

        // a, b, mode, step, dir, pos, err   (starts at ab=00, pos=4, x4)
        vecs[0]  = '{1'b1, 1'b0, M_X4,  1'b1, 1'b0, 4'd3,  8'd0};
        vecs[1]  = '{1'b1, 1'b1, M_X4,  1'b1, 1'b0, 4'd2,  8'd0};
        vecs[2]  = '{1'b1, 1'b0, M_X4,  1'b1, 1'b1, 4'd3,  8'd0};
        vecs[3]  = '{1'b0, 1'b1, M_X4,  1'b0, 1'b0, 4'd3,  8'd1};
        vecs[4]  = '{1'b0, 1'b0, M_X4,  1'b1, 1'b0, 4'd2,  8'd1};
        vecs[5]  = '{1'b0, 1'b0, M_X2,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[6]  = '{1'b0, 1'b1, M_X2,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[7]  = '{1'b1, 1'b1, M_X2,  1'b1, 1'b1, 4'd1,  8'd1};
        vecs[8]  = '{1'b1, 1'b0, M_X2,  1'b0, 1'b0, 4'd1,  8'd1};
        vecs[9]  = '{1'b0, 1'b0, M_X2,  1'b1, 1'b1, 4'd2,  8'd1};
        vecs[10] = '{1'b1, 1'b0, M_X2,  1'b1, 1'b0, 4'd1,  8'd1};
        vecs[11] = '{1'b1, 1'b0, M_X4,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[12] = '{1'b1, 1'b1, M_X4,  1'b1, 1'b0, 4'd15, 8'd1};
        vecs[13] = '{1'b1, 1'b1, M_X1,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[14] = '{1'b1, 1'b0, M_X1,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[15] = '{1'b0, 1'b0, M_X1,  1'b1, 1'b1, 4'd1,  8'd1};
        vecs[16] = '{1'b0, 1'b1, M_X1,  1'b0, 1'b0, 4'd1,  8'd1};
        vecs[17] = '{1'b1, 1'b1, M_X1,  1'b0, 1'b0, 4'd1,  8'd1};
        vecs[18] = '{1'b0, 1'b1, M_X1,  1'b0, 1'b0, 4'd1,  8'd1};
        vecs[19] = '{1'b0, 1'b0, M_X1,  1'b0, 1'b0, 4'd1,  8'd1};
        vecs[20] = '{1'b1, 1'b0, M_X1,  1'b1, 1'b0, 4'd0,  8'd1};
        vecs[21] = '{1'b1, 1'b1, M_X1,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[22] = '{1'b0, 1'b1, M_X1,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[23] = '{1'b0, 1'b0, M_X1,  1'b0, 1'b0, 4'd0,  8'd1};
        vecs[24] = '{1'b1, 1'b0, M_X1,  1'b1, 1'b0, 4'd3,  8'd1};
        vecs[25] = '{1'b1, 1'b0, M_RSV, 1'b0, 1'b0, 4'd0,  8'd1};
        vecs[26] = '{1'b1, 1'b1, M_RSV, 1'b1, 1'b0, 4'd15, 8'd1};
        vecs[27] = '{1'b1, 1'b1, M_X4,  1'b0, 1'b0, 4'd0,  8'd1};

        rst       = 1'b1;
        a_in      = 1'b0;
        b_in      = 1'b0;
        z_in      = 1'b0;
        mode      = M_X4;
        zero_req  = 1'b0;
        index_arm = 1'b0;
        tick(3);
        check_all_zero("reset");
        rst = 1'b0;
        tick(3);
        chk("post_reset_pos", 32'(pos), 32'd0);

        // Twenty CW steps, ten clocks apart: wraps through 15 -> 0 to 4.
        ab = 2'b00;
        for (int i = 0; i < 20; i++) begin
            ab = cw_next(ab);
            {a_in, b_in} = ab;
            expect_step(4'((i + 1) % 16), 1'b1, 1'b1, (i == 0) ? PER_MAX : 32'd10);
            tick(10);
        end
        chk("cw20_pos", 32'(pos), 32'd4);
        chk("cw20_steps", 32'(steps_seen), 32'd20);

        // Table of transitions across modes.
        for (int i = 0; i < NVEC; i++) begin
            a_in = vecs[i].a;
            b_in = vecs[i].b;
            mode = vecs[i].mode;
            if (vecs[i].step) expect_step(vecs[i].pos, vecs[i].dir, 1'b0, 32'd0);
            tick(12);
            chk($sformatf("vec%0d_pos", i), 32'(pos), 32'(vecs[i].pos));
            chk($sformatf("vec%0d_err", i), 32'(err_cnt), 32'(vecs[i].err));
            chk($sformatf("vec%0d_drained", i), 32'(sb_q.size()), 32'd0);
        end

        // 3-cycle glitch on A must be swallowed (ab=11, pos=0, x4).
        s = steps_seen;
        a_in = 1'b0;
        tick(3);
        a_in = 1'b1;
        tick(20);
        chk("glitch3_steps", 32'(steps_seen - s), 32'd0);
        chk("glitch3_pos", 32'(pos), 32'd0);

        // Clean A edge: step_pulse lands on exactly the 8th edge.
        a_in = 1'b0;
        expect_step(4'd15, 1'b0, 1'b0, 32'd0);
        tick(7);
        chk("latency_edge7", 32'(step_pulse), 32'd0);
        tick(1);
        chk("latency_edge8", 32'(step_pulse), 32'd1);
        tick(10);

        // 5-cycle pulse on A passes the filter: one step per edge.
        s = steps_seen;
        a_in = 1'b1;
        expect_step(4'd0, 1'b1, 1'b0, 32'd0);
        expect_step(4'd15, 1'b0, 1'b0, 32'd0);
        tick(5);
        a_in = 1'b0;
        tick(25);
        chk("pulse5_steps", 32'(steps_seen - s), 32'd2);
        chk("pulse5_pos", 32'(pos), 32'd15);

        // Illegal 00 -> 11 jumps.
        b_in = 1'b0;
        expect_step(4'd14, 1'b0, 1'b0, 32'd0);
        tick(12);
        s = illegal_seen;
        a_in = 1'b1;
        b_in = 1'b1;
        tick(10);
        chk("illegal_width", 32'(illegal_seen - s), 32'd1);
        chk("illegal_err", 32'(err_cnt), 32'd2);
        chk("illegal_pos", 32'(pos), 32'd14);
        for (int k = 0; k < 300; k++) begin
            a_in = ~a_in;
            b_in = ~b_in;
            tick(6);
        end
        tick(6);
        chk("illegal_sat_err", 32'(err_cnt), 32'd255);
        chk("illegal_sat_pos", 32'(pos), 32'd14);
        chk("illegal_sat_count", 32'(illegal_seen - s), 32'd301);

        // zero_req alone, then walk to pos 9.
        zero_req = 1'b1;
        tick(1);
        zero_req = 1'b0;
        chk("zero_req_pos", 32'(pos), 32'd0);
        ab = 2'b11;
        for (int i = 0; i < 9; i++) begin
            ab = cw_next(ab);
            {a_in, b_in} = ab;
            expect_step(4'(i + 1), 1'b1, 1'b0, 32'd0);
            tick(10);
        end
        chk("walk9_pos", 32'(pos), 32'd9);

        // Armed index with simultaneous CW step.
        index_arm = 1'b1;
        tick(1);
        index_arm = 1'b0;
        chk("armed_set", 32'(index_armed), 32'd1);
        s = ivalid_seen;
        z_in = 1'b1;
        {a_in, b_in} = 2'b00;
        expect_step(4'd0, 1'b1, 1'b0, 32'd0);
        tick(12);
        chk("index_pos", 32'(index_pos), 32'd9);
        chk("index_valid_pulses", 32'(ivalid_seen - s), 32'd1);
        chk("index_pos_cleared", 32'(pos), 32'd0);
        chk("index_disarmed", 32'(index_armed), 32'd0);
        z_in = 1'b0;
        tick(10);

        // zero_req on the very cycle a CW step lands.
        {a_in, b_in} = 2'b01;
        expect_step(4'd0, 1'b1, 1'b0, 32'd0);
        tick(7);
        zero_req = 1'b1;
        tick(1);
        zero_req = 1'b0;
        chk("zero_vs_step_pos", 32'(pos), 32'd0);
        tick(5);
        chk("zero_vs_step_hold", 32'(pos), 32'd0);

        // Reset during a pending filter count and armed index.
        b_in = 1'b0;
        expect_step(4'd15, 1'b0, 1'b0, 32'd0);
        tick(12);
        index_arm = 1'b1;
        tick(1);
        index_arm = 1'b0;
        chk("rearm", 32'(index_armed), 32'd1);
        a_in = 1'b1;
        tick(5);
        s = steps_seen;
        rst  = 1'b1;
        a_in = 1'b0;
        #1;
        check_all_zero("midrst");
        tick(2);
        rst = 1'b0;
        tick(15);
        chk("midrst_no_step", 32'(steps_seen - s), 32'd0);
        chk("midrst_armed", 32'(index_armed), 32'd0);
        b_in = 1'b1;
        expect_step(4'd1, 1'b1, 1'b1, PER_MAX);
        tick(12);
        chk("midrst_first_pos", 32'(pos), 32'd1);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/quad_decoder_idx.md
QUAD_DECODER_IDX -- requirements
Module: quad_decoder_idx

Interface
REQ-001 Parameter CPR, default 4096, encoder lines per revolution (any integer 2..65535).
REQ-002 Parameter FILT_LEN, default 4, consecutive stable samples needed per channel (1..15).
REQ-003 Parameter PER_W, default 20, width of the step-period measurement.
REQ-004 Parameter INDEX_ZERO, default 1'b1, clears position on the captured index edge.
REQ-005 Parameters INVERT_A, INVERT_B, INVERT_Z, default 1'b0, invert the corresponding raw input.
REQ-006 Derived POS_W = clog2(4*CPR), position width.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  reset, asynchronous, active-high.
REQ-009 a_in, b_in, z_in  in  1 each  asynchronous encoder A/B/index inputs.
REQ-010 mode  in  2  decode mode: 00=x1, 01=x2, 10=x4, 11=reserved (treated as x4).
REQ-011 zero_req  in  1  synchronous position clear.
REQ-012 index_arm  in  1  single-cycle pulse arming index capture.
REQ-013 pos  out  POS_W  position count; step_pulse, dir, illegal  out  1 each.
REQ-014 err_cnt  out  8  saturating illegal-transition count.
REQ-015 index_pos  out  POS_W; index_valid, index_armed  out  1 each.
REQ-016 period  out  PER_W  clocks between accepted steps; period_valid  out  1.

Function
REQ-017 Each raw input SHALL pass a 3-flop synchroniser, then a glitch filter whose output changes only after FILT_LEN consecutive identical samples differing from its current value.
REQ-018 Decoding SHALL use filtered {A,B}; CW sequence 00->01->11->10->00, reverse is ACW.
REQ-019 Both bits changing in one cycle SHALL pulse illegal for 1 cycle, increment err_cnt (saturate 255), and leave pos unchanged.
REQ-020 Counted transitions: x4 every legal transition; x2 legal transitions where A changes; x1 only 10->00 (CW) and 00->10 (ACW).
REQ-021 Modulus M = CPR*{1,2,4} per mode; CW at M-1 wraps to 0; ACW at 0 wraps to M-1.
REQ-022 A counted transition SHALL pulse step_pulse for 1 cycle, set dir (1=CW) and update pos in the same cycle.
REQ-023 Latency: a clean a_in edge SHALL produce step_pulse exactly FILT_LEN+4 rising edges after first sampling.
REQ-024 A change of mode SHALL clear pos to 0 on the next cycle; no step is counted that cycle.
REQ-025 zero_req SHALL set pos to 0, overriding any same-cycle step and index clear; step_pulse still reports.
REQ-026 First cycle after reset SHALL only seed the previous-state register; no step or illegal.
REQ-027 index_arm SHALL set index_armed; armed and a filtered Z rising edge SHALL latch index_pos with the pre-update pos, pulse index_valid, clear index_armed.
REQ-028 With INDEX_ZERO=1, the capture SHALL force pos to 0, overriding a same-cycle step; index_arm while armed is ignored.
REQ-029 Period counter SHALL increment each cycle saturating at 2^PER_W-1; on counted step, period <= counter+1 (saturated), period_valid pulses, counter <= 0.

Reset
REQ-030 rst SHALL clear pos, index_pos, err_cnt, period, all pulses, dir, index_armed, synchronisers, filters to 0; period counter to 2^PER_W-1.
REQ-031 rst mid-operation SHALL abort any pending filter count and index arm; the first step after reset reports period = 2^PER_W-1.

Structure
REQ-032 Package quad_pkg SHALL hold mode encodings, the POS_W clog2 function and the transition-decode constants.
REQ-033 Sub-module quad_glitch_filter (sync+filter, FILT_LEN parameter) SHALL be instantiated three times.

Verification
REQ-034 CPR=4, x4, 20 CW steps spaced 10 clocks -> pos 0..15 then wraps to 4, 20 step_pulses dir=1, period=10 from the second pulse.
REQ-035 x4 pos=0, one ACW step -> pos=15; switch to x1 -> pos=0; full CW cycle -> pos=1.
REQ-036 FILT_LEN=4, 3-cycle glitch on a_in -> no step_pulse, pos unchanged; 5-cycle pulse -> one step.
REQ-037 Force 00->11 -> illegal 1 cycle, err_cnt=1, pos unchanged; 300 such events -> err_cnt=255.
REQ-038 pos=9, arm, Z rise with simultaneous CW step -> index_pos=9, index_valid, pos=0, index_armed=0; add zero_req -> pos=0.
REQ-039 Assert rst during filter count and armed index -> all outputs 0 next cycle, first later step reports period=2^PER_W-1.
